// File: rtl/edge_train_gen.sv
// Edge-train transmitter: toggles the line output cmd_edges times, spaced gap+1 clocks apart.
// Optional EDGE_TRAIN_MIN_GAP_EN clamps the gap to at least 2 (spacing >= 3 clocks).
module edge_train_gen #(
  parameter int   CNT_W      = 8,
  parameter int   GAP_W      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_edges,
  input  logic [GAP_W-1:0] cmd_gap,
  input  logic             abort,
  output logic             line,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edges_left
);

  typedef enum logic [1:0] {S_IDLE, S_TOGGLE, S_GAP, S_DONE} state_t;

  state_t           state, state_nx;
  logic             line_nx;
  logic [CNT_W-1:0] edges_nx;
  logic [GAP_W-1:0] gap_reg, gap_reg_nx;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nx;
  logic [GAP_W-1:0] eff_gap;

`ifdef EDGE_TRAIN_MIN_GAP_EN
  assign eff_gap = (cmd_gap < GAP_W'(2)) ? GAP_W'(2) : cmd_gap;
`else
  assign eff_gap = cmd_gap;
`endif

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      line       <= IDLE_LEVEL;
      edges_left <= '0;
      gap_reg    <= '0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_nx;
      line       <= line_nx;
      edges_left <= edges_nx;
      gap_reg    <= gap_reg_nx;
      gap_cnt    <= gap_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    line_nx    = line;
    edges_nx   = edges_left;
    gap_reg_nx = gap_reg;
    gap_cnt_nx = gap_cnt;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_edges == '0) begin
            state_nx = S_DONE;
          end else begin
            edges_nx   = cmd_edges;
            gap_reg_nx = eff_gap;
            state_nx   = S_TOGGLE;
          end
        end
      end
      S_TOGGLE: begin
        // abort wins over a coincident toggle
        if (abort) begin
          edges_nx = '0;
          state_nx = S_DONE;
        end else begin
          line_nx  = ~line;
          edges_nx = edges_left - CNT_W'(1);
          if (edges_left == CNT_W'(1)) begin
            state_nx = S_DONE;
          end else if (gap_reg == '0) begin
            state_nx = S_TOGGLE;
          end else begin
            gap_cnt_nx = gap_reg;
            state_nx   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          edges_nx = '0;
          state_nx = S_DONE;
        end else begin
          gap_cnt_nx = gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) state_nx = S_TOGGLE;
        end
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_edge_train_gen.sv
// Scoreboard bench for edge_train_gen: driver pushes expected train outcomes,
// a negedge monitor checks every toggle and every done pulse against them.
module tb_edge_train_gen;
  localparam int   CNT_W = 8;
  localparam int   GAP_W = 8;
  localparam logic IDLE_LEVEL = 1'b0;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_edges;
  logic [GAP_W-1:0] cmd_gap;
  logic             abort;
  logic             line;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] edges_left;

  edge_train_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W), .IDLE_LEVEL(IDLE_LEVEL)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_edges(cmd_edges), .cmd_gap(cmd_gap), .abort(abort), .line(line),
    .busy(busy), .done(done), .edges_left(edges_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   h;       // handshake edge
    int   e;       // commanded edges
    int   g;       // effective gap
    int   toggles; // toggles expected before done
    int   done_at; // edge after which done is high
    logic fin;     // final line level
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic model_line = IDLE_LEVEL;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor
  int   tcnt = 0;
  logic prev_line = IDLE_LEVEL;
  always @(negedge clk) begin
    if (reset) begin
      tcnt = 0;
    end else begin
      if (line !== prev_line) begin
        tcnt++;
        if (sb.size() == 0) check("unexpected_toggle", 1, 0);
        else begin
          check("toggle_edge", cyc, sb[0].h + 1 + (tcnt - 1) * (sb[0].g + 1));
          check("edges_left_at_toggle", edges_left, sb[0].e - tcnt);
        end
      end
      if (done === 1'b1) begin
        if (sb.size() == 0) check("unexpected_done", 1, 0);
        else begin
          exp_t x;
          x = sb.pop_front();
          check("done_edge", cyc, x.done_at);
          check("toggle_count", tcnt, x.toggles);
          check("final_line", line, x.fin);
          check("edges_left_done", edges_left, 0);
          check("busy_in_done", busy, 1);
          check("ready_in_done", cmd_ready, 0);
        end
        tcnt = 0;
      end
    end
    prev_line = line;
  end

  // Higher-level model: toggle k lands at h+1+k*(g+1); an abort at edge a
  // inside the train cuts it to the toggles that landed before a.
  task automatic issue(input int e, input int gin, input int abort_rel, input bit abort_idle);
    exp_t x;
    int   g, last, a, span;
    int   budget = 0;
    while (cmd_ready !== 1'b1 && budget < 2000) begin @(negedge clk); budget++; end
    if (budget >= 2000) begin check("ready_timeout", 0, 1); return; end
    g = gin;
`ifdef EDGE_TRAIN_MIN_GAP_EN
    if (g < 2) g = 2;
`endif
    cmd_valid = 1'b1;
    cmd_edges = CNT_W'(e);
    cmd_gap   = GAP_W'(gin);
    abort     = abort_idle;
    x.h = cyc + 1;
    x.e = e;
    x.g = g;
    last = (e == 0) ? x.h : x.h + 1 + (e - 1) * (g + 1);
    span = last - x.h;
    a = (abort_rel > 0) ? x.h + abort_rel : -1;
    if (e > 0 && a >= x.h + 1 && a <= last) begin
      x.toggles = (a - x.h - 1 + g) / (g + 1);
      x.done_at = a;
    end else begin
      x.toggles = e;
      x.done_at = last;
    end
    x.fin = model_line ^ x.toggles[0];
    model_line = x.fin;
    sb.push_back(x);
    @(negedge clk);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    cmd_edges = CNT_W'($urandom);
    cmd_gap   = GAP_W'($urandom);
    if (abort_rel > 0 && abort_rel <= span + 2) begin
      while (cyc < a - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
  endtask

  initial begin
    int e, g, ar;
    reset = 1'b1; cmd_valid = 1'b0; cmd_edges = '0; cmd_gap = '0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_line", line, IDLE_LEVEL);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_edges_left", edges_left, 0);
    reset = 1'b0;
    @(negedge clk);

    // directed
    issue(3, 2, 0, 0);
    issue(0, 5, 0, 0);
    issue(4, 0, 0, 0);
    issue(5, 1, 5, 0);   // abort on the 3rd toggle's edge
    issue(1, 3, 0, 1);   // abort together with cmd_valid in IDLE
    issue(2, 1, 4, 0);   // abort landing in DONE: no effect

    // reset in the middle of a GAP
    issue(10, 3, 0, 0);
    while (cyc < sb[0].h + 3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    sb.delete();
    model_line = IDLE_LEVEL;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_line", line, IDLE_LEVEL);
    check("midrst_ready", cmd_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_edges_left", edges_left, 0);

    // full-width count
    issue(255, 0, 0, 0);

    // random
    for (int i = 0; i < 40; i++) begin
      e  = $urandom_range(0, 12);
      g  = $urandom_range(0, 4);
      ar = ($urandom_range(0, 3) == 0) ? $urandom_range(1, e * (g + 1) + 3) : 0;
      issue(e, g, ar, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    begin
      int budget = 0;
      while ((sb.size() != 0 || cmd_ready !== 1'b1) && budget < 5000) begin
        @(negedge clk); budget++;
      end
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
